// File: rtl/s2mm_fb_sched.sv
// s2mm_fb_sched: frame-buffer scheduler for the stream-to-memory write engine.
// Rotates the engine's base address over C_BUF_NUM equally spaced buffers,
// skipping the buffer held by the reader. Publishes the last completed buffer.
// Sequences soft_resetn so that an in-flight burst always drains before idling.
// Optional statistics counters (frame_cnt/drop_cnt): define FB_SCHED_STATS_EN.
module s2mm_fb_sched #(
  parameter int C_ADDR_WIDTH     = 32,
  parameter int C_BUF_NUM        = 3,
  parameter int C_BUF_IDX_BITS   = 2,
  parameter int C_FRAME_CNT_BITS = 16
) (
  input  logic                        M_AXI_ACLK,
  input  logic                        M_AXI_ARESETN,
  input  logic                        enable,
  input  logic [C_ADDR_WIDTH-1:0]     buf_base_addr,
  input  logic [C_ADDR_WIDTH-1:0]     buf_stride,
  input  logic [C_BUF_IDX_BITS-1:0]   rd_buf_idx,
  input  logic                        rd_buf_valid,
  input  logic                        frame_pulse,
  input  logic                        resetting,
  output logic                        soft_resetn,
  output logic [C_ADDR_WIDTH-1:0]     base_addr,
  output logic [C_BUF_IDX_BITS-1:0]   wr_buf_idx,
  output logic [C_BUF_IDX_BITS-1:0]   done_buf_idx,
  output logic                        done_valid,
  output logic                        frame_done,
  output logic                        busy,
  output logic [C_FRAME_CNT_BITS-1:0] frame_cnt,
  output logic [C_FRAME_CNT_BITS-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [C_BUF_IDX_BITS-1:0] LAST_IDX = C_BUF_IDX_BITS'(C_BUF_NUM - 1);
  localparam logic [C_BUF_IDX_BITS-1:0] ZERO_IDX = {C_BUF_IDX_BITS{1'b0}};
  localparam logic [C_BUF_IDX_BITS-1:0] ONE_IDX  = C_BUF_IDX_BITS'(1);
  localparam logic [C_ADDR_WIDTH-1:0]   ZERO_ADDR = {C_ADDR_WIDTH{1'b0}};

  // Next buffer in rotation order, wrapping the last buffer back to buffer 0.
  function automatic logic [C_BUF_IDX_BITS-1:0] idx_inc(input logic [C_BUF_IDX_BITS-1:0] idx);
    logic [C_BUF_IDX_BITS-1:0] res;
    if (idx >= LAST_IDX) res = ZERO_IDX;
    else                 res = idx + ONE_IDX;
    return res;
  endfunction

  // Byte address of a buffer; the product is deliberately truncated.
  function automatic logic [C_ADDR_WIDTH-1:0] buf_addr(input logic [C_ADDR_WIDTH-1:0] base,
                                                      input logic [C_ADDR_WIDTH-1:0] stride,
                                                      input logic [C_BUF_IDX_BITS-1:0] idx);
    return base + C_ADDR_WIDTH'(idx) * stride;
  endfunction

  state_t                      state_r, state_nxt_s;
  logic                        drain_met_r;
  logic                        soft_resetn_r, busy_r, done_valid_r, frame_done_r;
  logic [C_ADDR_WIDTH-1:0]     base_addr_r;
  logic [C_BUF_IDX_BITS-1:0]   wr_buf_idx_r, done_buf_idx_r;
  logic [C_BUF_IDX_BITS-1:0]   cand1_s, next_idx_s;
  logic                        rd_hit_s, accept_s;

  // A frame completion only counts while the engine is live (RUN or DRAIN).
  assign accept_s = frame_pulse && (state_r != ST_IDLE);

  // Next-state logic: IDLE -> RUN -> DRAIN (>=2 cycles, until drained) -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable && !resetting) state_nxt_s = ST_RUN;
        else                      state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (!enable) state_nxt_s = ST_DRAIN;
        else         state_nxt_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (drain_met_r && !resetting) state_nxt_s = ST_IDLE;
        else                           state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Pick the next write buffer, hopping over the reader's buffer once; with two
  // buffers the hop lands back on the current one, which means stay in place.
  always_comb begin
    cand1_s  = idx_inc(wr_buf_idx_r);
    rd_hit_s = rd_buf_valid && (rd_buf_idx <= LAST_IDX) && (rd_buf_idx == cand1_s);
    if (rd_hit_s) next_idx_s = idx_inc(cand1_s);
    else          next_idx_s = cand1_s;
  end

  // State register and drain residency flag (set after the first DRAIN cycle).
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_r     <= ST_IDLE;
      drain_met_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      drain_met_r <= (state_r == ST_DRAIN);
    end
  end

  // Registered outputs: engine control, buffer rotation and completion reporting.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      soft_resetn_r  <= 1'b0;
      busy_r         <= 1'b0;
      base_addr_r    <= ZERO_ADDR;
      wr_buf_idx_r   <= ZERO_IDX;
      done_buf_idx_r <= ZERO_IDX;
      done_valid_r   <= 1'b0;
      frame_done_r   <= 1'b0;
    end else begin
      soft_resetn_r <= (state_nxt_s == ST_RUN);
      busy_r        <= (state_nxt_s != ST_IDLE);
      frame_done_r  <= accept_s;
      if (accept_s) begin
        done_buf_idx_r <= wr_buf_idx_r;
        done_valid_r   <= 1'b1;
        wr_buf_idx_r   <= next_idx_s;
        base_addr_r    <= buf_addr(buf_base_addr, buf_stride, next_idx_s);
      end else if (state_r == ST_IDLE) begin
        // Keep the address current so it is valid when soft_resetn rises.
        base_addr_r <= buf_addr(buf_base_addr, buf_stride, wr_buf_idx_r);
      end
    end
  end

  assign soft_resetn  = soft_resetn_r;
  assign busy         = busy_r;
  assign base_addr    = base_addr_r;
  assign wr_buf_idx   = wr_buf_idx_r;
  assign done_buf_idx = done_buf_idx_r;
  assign done_valid   = done_valid_r;
  assign frame_done   = frame_done_r;

`ifdef FB_SCHED_STATS_EN
  localparam logic [C_FRAME_CNT_BITS-1:0] CNT_ZERO = {C_FRAME_CNT_BITS{1'b0}};
  localparam logic [C_FRAME_CNT_BITS-1:0] CNT_ONE  = C_FRAME_CNT_BITS'(1);

  logic [C_FRAME_CNT_BITS-1:0] frame_cnt_r, drop_cnt_r;
  logic                        drop_s;

  // A drop is a completed frame whose successor buffer is the same buffer.
  assign drop_s = (next_idx_s == wr_buf_idx_r);

  // Wrapping statistics counters, cleared only by reset.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      frame_cnt_r <= CNT_ZERO;
      drop_cnt_r  <= CNT_ZERO;
    end else if (accept_s) begin
      frame_cnt_r <= frame_cnt_r + CNT_ONE;
      if (drop_s) drop_cnt_r <= drop_cnt_r + CNT_ONE;
    end
  end

  assign frame_cnt = frame_cnt_r;
  assign drop_cnt  = drop_cnt_r;
`else
  assign frame_cnt = {C_FRAME_CNT_BITS{1'b0}};
  assign drop_cnt  = {C_FRAME_CNT_BITS{1'b0}};
`endif

endmodule

// File: tb/tb_s2mm_fb_sched.sv
// Self-checking bench for s2mm_fb_sched. Two instances (3 and 2 buffers) share
// the stimulus; a behavioural model predicts buffer rotation and completion.
module tb_s2mm_fb_sched;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] buf_base_addr;
  logic [31:0] buf_stride;
  logic [1:0]  rd_buf_idx;
  logic        rd_buf_valid;
  logic        frame_pulse;
  logic        resetting;

  logic        a_sr, a_busy, a_dv, a_fd;
  logic [31:0] a_base;
  logic [1:0]  a_wr, a_done;
  logic [15:0] a_fcnt, a_dcnt;
  logic        b_sr, b_busy, b_dv, b_fd;
  logic [31:0] b_base;
  logic [1:0]  b_wr, b_done;
  logic [15:0] b_fcnt, b_dcnt;

  int checks   = 0;
  int failures = 0;

  // Model state: index 0 = three-buffer instance, index 1 = two-buffer instance.
  logic [1:0]  m_wr   [2];
  logic [1:0]  m_done [2];
  logic [15:0] m_fcnt [2];
  logic [15:0] m_dcnt [2];
  logic        m_dv, m_fd, m_base_live;
  logic        exp_sr, exp_busy, cur_busy;

  s2mm_fb_sched #(.C_ADDR_WIDTH(32), .C_BUF_NUM(3), .C_BUF_IDX_BITS(2), .C_FRAME_CNT_BITS(16)) u_dut_a (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .enable(enable),
    .buf_base_addr(buf_base_addr), .buf_stride(buf_stride),
    .rd_buf_idx(rd_buf_idx), .rd_buf_valid(rd_buf_valid),
    .frame_pulse(frame_pulse), .resetting(resetting),
    .soft_resetn(a_sr), .base_addr(a_base), .wr_buf_idx(a_wr),
    .done_buf_idx(a_done), .done_valid(a_dv), .frame_done(a_fd),
    .busy(a_busy), .frame_cnt(a_fcnt), .drop_cnt(a_dcnt));

  s2mm_fb_sched #(.C_ADDR_WIDTH(32), .C_BUF_NUM(2), .C_BUF_IDX_BITS(2), .C_FRAME_CNT_BITS(16)) u_dut_b (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .enable(enable),
    .buf_base_addr(buf_base_addr), .buf_stride(buf_stride),
    .rd_buf_idx(rd_buf_idx), .rd_buf_valid(rd_buf_valid),
    .frame_pulse(frame_pulse), .resetting(resetting),
    .soft_resetn(b_sr), .base_addr(b_base), .wr_buf_idx(b_wr),
    .done_buf_idx(b_done), .done_valid(b_dv), .frame_done(b_fd),
    .busy(b_busy), .frame_cnt(b_fcnt), .drop_cnt(b_dcnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nbuf_of(input int d);
    return (d == 0) ? 3 : 2;
  endfunction

  // First buffer after wr (in rotation order) the reader does not own; stay if none.
  function automatic logic [1:0] pick_next(input logic [1:0] wr, input int nbuf,
                                           input logic [1:0] rd, input logic rdv);
    for (int k = 1; k < nbuf; k++) begin
      int c;
      c = (int'(wr) + k) % nbuf;
      if (!(rdv && (int'(rd) == c))) return 2'(c);
    end
    return wr;
  endfunction

  function automatic logic [31:0] exp_base(input int d);
    if (!m_base_live) return 32'h0;
    return buf_base_addr + 32'(m_wr[d]) * buf_stride;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string tag, input int d, input logic sr, input logic bsy,
                           input logic [31:0] base, input logic [1:0] wr, input logic [1:0] done,
                           input logic dv, input logic fd, input logic [15:0] fc, input logic [15:0] dc);
    logic [15:0] efc, edc;
`ifdef FB_SCHED_STATS_EN
    efc = m_fcnt[d];
    edc = m_dcnt[d];
`else
    efc = 16'h0;
    edc = 16'h0;
`endif
    chk({tag, ".soft_resetn"}, 64'(sr), 64'(exp_sr));
    chk({tag, ".busy"}, 64'(bsy), 64'(exp_busy));
    chk({tag, ".base_addr"}, 64'(base), 64'(exp_base(d)));
    chk({tag, ".wr_buf_idx"}, 64'(wr), 64'(m_wr[d]));
    chk({tag, ".done_buf_idx"}, 64'(done), 64'(m_done[d]));
    chk({tag, ".done_valid"}, 64'(dv), 64'(m_dv));
    chk({tag, ".frame_done"}, 64'(fd), 64'(m_fd));
    chk({tag, ".frame_cnt"}, 64'(fc), 64'(efc));
    chk({tag, ".drop_cnt"}, 64'(dc), 64'(edc));
  endtask

  task automatic check_all(input string ph);
    check_dut({ph, ".a"}, 0, a_sr, a_busy, a_base, a_wr, a_done, a_dv, a_fd, a_fcnt, a_dcnt);
    check_dut({ph, ".b"}, 1, b_sr, b_busy, b_base, b_wr, b_done, b_dv, b_fd, b_fcnt, b_dcnt);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_wr[d] = 2'd0; m_done[d] = 2'd0; m_fcnt[d] = 16'd0; m_dcnt[d] = 16'd0;
    end
    m_dv = 1'b0; m_fd = 1'b0; m_base_live = 1'b0;
    exp_sr = 1'b0; exp_busy = 1'b0; cur_busy = 1'b0;
  endtask

  // One clock edge: predict from the inputs now driven, then compare after the edge.
  // exp_sr/exp_busy are set by the caller to the levels expected after this edge.
  task automatic tick(input string ph);
    logic       acc;
    logic [1:0] n;
    acc = frame_pulse && cur_busy;
    for (int d = 0; d < 2; d++) begin
      if (acc) begin
        n = pick_next(m_wr[d], nbuf_of(d), rd_buf_idx, rd_buf_valid);
        m_done[d] = m_wr[d];
        m_fcnt[d] = m_fcnt[d] + 16'd1;
        if (n == m_wr[d]) m_dcnt[d] = m_dcnt[d] + 16'd1;
        m_wr[d] = n;
      end
    end
    if (acc) m_dv = 1'b1;
    m_fd = acc;
    @(posedge clk);
    #1;
    m_base_live = 1'b1;
    cur_busy = exp_busy;
    check_all(ph);
  endtask

  initial begin
    logic prev_pulse;
    rst_n = 1'b0; enable = 1'b0; frame_pulse = 1'b0; resetting = 1'b0;
    rd_buf_idx = 2'd0; rd_buf_valid = 1'b0;
    buf_base_addr = 32'h1000_0000; buf_stride = 32'h0010_0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Idle: address tracks buffer 0; a frame pulse in IDLE is ignored.
    tick("idle");
    frame_pulse = 1'b1;
    tick("idle_pulse");
    frame_pulse = 1'b0;
    chk("idle.base_valid", 64'(a_base), 64'h1000_0000);

    // Test 1: enable, three frames with no reader.
    enable = 1'b1; exp_sr = 1'b1; exp_busy = 1'b1;
    tick("t1.enable");
    for (int i = 0; i < 3; i++) begin
      frame_pulse = 1'b1;
      tick("t1.pulse");
      frame_pulse = 1'b0;
      if (i == 0) chk("t1.base_after_1", 64'(a_base), 64'h1010_0000);
      if (i == 1) chk("t1.base_after_2", 64'(a_base), 64'h1020_0000);
      tick("t1.gap");
    end
    chk("t1.wr_wrapped", 64'(a_wr), 64'd0);

    // Test 2: reader owns buffer 1 -> three-buffer instance jumps 0 -> 2.
    rd_buf_valid = 1'b1; rd_buf_idx = 2'd1; frame_pulse = 1'b1;
    tick("t2.pulse");
    frame_pulse = 1'b0;
    chk("t2.skip_idx", 64'(a_wr), 64'd2);
    chk("t2.skip_base", 64'(a_base), 64'h1020_0000);
    tick("t2.gap");

    // Test 3: two-buffer instance at 0 with reader on 1 stays in place.
    frame_pulse = 1'b1;
    tick("t3.pulse");
    frame_pulse = 1'b0;
    chk("t3.stay_idx", 64'(b_wr), 64'd0);
    chk("t3.stay_done", 64'(b_done), 64'd0);
    tick("t3.gap");

    // Randomized running traffic with a wandering reader.
    prev_pulse = 1'b0;
    for (int i = 0; i < 150; i++) begin
      rd_buf_idx   = 2'($urandom_range(0, 3));
      rd_buf_valid = 1'($urandom_range(0, 1));
      frame_pulse  = !prev_pulse && ($urandom_range(0, 2) == 0);
      prev_pulse   = frame_pulse;
      tick("rand");
    end
    frame_pulse = 1'b0;

    // Test 4: disable while the engine reports resetting for 10 cycles.
    enable = 1'b0; resetting = 1'b1; exp_sr = 1'b0; exp_busy = 1'b1;
    tick("t4.disable");
    for (int i = 0; i < 10; i++) begin
      enable      = (i >= 2 && i < 6);
      frame_pulse = (i == 4);
      tick("t4.drain");
    end
    enable = 1'b0; frame_pulse = 1'b0; resetting = 1'b0; exp_busy = 1'b0;
    tick("t4.idle");
    tick("t4.idle2");

    // Test 5: run briefly, disable with no resetting -> exactly 2 DRAIN cycles.
    enable = 1'b1; exp_sr = 1'b1; exp_busy = 1'b1;
    tick("t5.enable");
    rd_buf_valid = 1'b0; frame_pulse = 1'b1;
    tick("t5.pulse");
    frame_pulse = 1'b0;
    enable = 1'b0; exp_sr = 1'b0;
    tick("t5.drain1");
    tick("t5.drain2");
    exp_busy = 1'b0;
    tick("t5.idle");
    tick("t5.idle2");
    enable = 1'b1; exp_sr = 1'b1; exp_busy = 1'b1;
    tick("t5.reenable");

    // Test 6: asynchronous reset between edges while running mid-frame.
    frame_pulse = 1'b1;
    tick("t6.pulse");
    frame_pulse = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6.async_reset");
    @(posedge clk);
    #1;
    check_all("t6.held_reset");
    rst_n = 1'b1;
    enable = 1'b0;
    tick("t6.idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/s2mm_fb_sched.md
Name: s2mm_fb_sched

Overview:
- Frame-buffer scheduler for the stream-to-memory write engine.
- Rotates the engine's frame base address across C_BUF_NUM equally-spaced buffers, skipping the buffer currently held by the display/read side.
- Publishes the most recently completed buffer to the reader.
- Sequences the engine's soft_resetn on enable/disable so that an in-flight AXI burst always drains cleanly.

Parameters:
C_ADDR_WIDTH, 32, width of base/stride/address buses
C_BUF_NUM, 3, number of frame buffers; legal 2..4
C_BUF_IDX_BITS, 2, width of buffer index buses
C_FRAME_CNT_BITS, 16, width of statistics counters (optional feature)

Ports:
M_AXI_ACLK  in  1  clock; one clock domain
M_AXI_ARESETN  in  1  reset, asynchronous assert, active-low
enable  in  1  level; 1 = capture frames
buf_base_addr  in  C_ADDR_WIDTH  address of buffer 0; static while enable=1
buf_stride  in  C_ADDR_WIDTH  byte distance between buffers; static while enable=1
rd_buf_idx  in  C_BUF_IDX_BITS  buffer index the reader currently owns
rd_buf_valid  in  1  rd_buf_idx meaningful
frame_pulse  in  1  single-cycle pulse from the write engine: final burst of a frame acknowledged
resetting  in  1  write engine still draining after soft reset
soft_resetn  out  1  to write engine; 0 = hold idle
base_addr  out  C_ADDR_WIDTH  to write engine; address of next frame
wr_buf_idx  out  C_BUF_IDX_BITS  buffer currently being written
done_buf_idx  out  C_BUF_IDX_BITS  last completed buffer
done_valid  out  1  sticky; at least one frame completed since reset
frame_done  out  1  one-cycle pulse, registered copy of an accepted frame_pulse
busy  out  1  1 in RUN or DRAIN
frame_cnt  out  C_FRAME_CNT_BITS  completed frames (optional feature)
drop_cnt  out  C_FRAME_CNT_BITS  frames overwritten in place (optional feature)

Behaviour:
- Reset values (async, M_AXI_ARESETN=0): state IDLE; soft_resetn=0; wr_buf_idx=0; done_buf_idx=0; done_valid=0; frame_done=0; busy=0; base_addr=0; counters=0.
- All outputs are registered.
- States:
  - IDLE: soft_resetn=0, busy=0; base_addr <= buf_base_addr + wr_buf_idx*buf_stride every cycle. If enable=1 and resetting=0: go to RUN. base_addr is already valid in the cycle soft_resetn rises.
  - RUN: soft_resetn=1, busy=1. If enable=0: go to DRAIN, soft_resetn<=0 on the same edge.
  - DRAIN: soft_resetn=0, busy=1; minimum residency 2 cycles to cover the engine's resetting assertion latency. Exit to IDLE when the residency is met and resetting=0. enable re-asserted during DRAIN is ignored until IDLE.
- Frame advance: on any cycle in RUN or DRAIN with frame_pulse=1:
  - done_buf_idx<=wr_buf_idx; done_valid<=1; frame_done<=1 for the next cycle only.
  - cand1 = wr_buf_idx+1, wrapping C_BUF_NUM-1 -> 0.
  - If rd_buf_valid and cand1==rd_buf_idx: cand2 = cand1+1 (wrapped); else cand2 = cand1.
  - If cand2==wr_buf_idx (only possible with C_BUF_NUM=2): stay on the current buffer (drop event). Otherwise wr_buf_idx<=cand2.
  - base_addr <= buf_base_addr + next_idx*buf_stride on the same edge. This is one edge after frame_pulse, ahead of the engine's next base-address sample, which occurs no earlier than 2 edges after.
- Address arithmetic: the product is truncated to C_ADDR_WIDTH, no overflow detection. Index is compared modulo C_BUF_NUM. rd_buf_idx >= C_BUF_NUM is treated as not matching.
- frame_pulse in IDLE is ignored, with no state change.
- wr_buf_idx persists across disable/enable; it is reset only by M_AXI_ARESETN.
- rd_buf_idx changing on the same edge as frame_pulse: the value sampled on that edge is used.
- Reset asserted mid-RUN: all state returns to reset values immediately, asynchronously.

Optional Feature:
- Macro FB_SCHED_STATS_EN.
- Defined:
  - frame_cnt increments (wrapping) on every accepted frame_pulse.
  - drop_cnt increments (wrapping) on every stay-in-place drop event.
  - Both clear only on reset.
- Undefined: both ports remain in the port list and are tied to 0; no counter logic is synthesized.

Test Plan:
1. Reset, C_BUF_NUM=3, base=0x1000_0000, stride=0x0010_0000, enable=1, rd_buf_valid=0, three frame_pulses -> wr_buf_idx 0->1->2->0; base_addr 0x1000_0000 -> 0x1010_0000 -> 0x1020_0000 -> 0x1000_0000; frame_done pulses 1 cycle after each; done_buf_idx 0,1,2.
2. C_BUF_NUM=3, wr_buf_idx=0, rd_buf_valid=1, rd_buf_idx=1, frame_pulse -> wr_buf_idx=2, base_addr=0x1020_0000.
3. C_BUF_NUM=2, wr_buf_idx=0, rd_buf_idx=1 valid, frame_pulse -> wr_buf_idx stays 0, done_buf_idx=0; with FB_SCHED_STATS_EN: drop_cnt=1, frame_cnt=1.
4. RUN, drop enable with resetting held 1 for 10 cycles -> soft_resetn=0 next edge, busy=1 for 10+ cycles, IDLE one edge after resetting falls. Re-enable during DRAIN is ignored.
5. Disable with resetting never asserted -> DRAIN exactly 2 cycles, then IDLE. Re-enable -> soft_resetn=1 with base_addr equal to the preserved wr_buf_idx buffer.
6. Assert M_AXI_ARESETN=0 mid-frame, asynchronously between clock edges -> all outputs go to reset values before the next edge.
